// File: rtl/seq_mult_n.sv
// Parametrised sequential shift-add multiplier: multiplier in B, multiplicand on Din,
// 2W-bit product left in {A,B}, one add-and-shift per cycle, signed or unsigned.
module seq_mult_n #(
   parameter int W = 8
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Load_B,
   input  logic         Start,
   input  logic         SignedMode,
   input  logic [W-1:0] Din,
   output logic [W-1:0] Aval,
   output logic [W-1:0] Bval,
   output logic         X,
   output logic         Busy,
   output logic         Done
);

   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   a, b, m;
   logic           x, sm;
   logic [CW-1:0]  count;
   logic           last, do_load, do_start, do_iter;
   logic [W:0]     ext_a, ext_m, sum;

   assign last = (count == CW'(W-1));

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      do_load   = 1'b0;
      do_start  = 1'b0;
      do_iter   = 1'b0;
      case (state)
         IDLE: begin
            if (Load_B) begin
               do_load = 1'b1;
            end else if (Start) begin
               do_start  = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            do_iter = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            // A load in DONE keeps the result state; otherwise wait for Start to drop.
            if (Load_B)      do_load   = 1'b1;
            else if (!Start) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The final multiplier bit carries weight -2^(W-1) in signed mode, hence a subtract.
   always_comb begin
      ext_a = sm ? {a[W-1], a} : {1'b0, a};
      ext_m = sm ? {m[W-1], m} : {1'b0, m};
      sum   = ext_a;
      if (b[0]) begin
         if (sm && last) sum = ext_a - ext_m;
         else            sum = ext_a + ext_m;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         a     <= '0;
         b     <= '0;
         m     <= '0;
         x     <= 1'b0;
         sm    <= 1'b0;
         count <= '0;
      end else begin
         state <= state_nxt;
         if (do_load) begin
            b <= Din;
            a <= '0;
            x <= 1'b0;
         end
         if (do_start) begin
            m     <= Din;
            sm    <= SignedMode;
            a     <= '0;
            x     <= 1'b0;
            count <= '0;
         end
         if (do_iter) begin
            a     <= sum[W:1];
            b     <= {sum[0], b[W-1:1]};
            x     <= sm & sum[W];
            count <= count + CW'(1);
         end
      end
   end

   assign Aval = a;
   assign Bval = b;
   assign X    = x;
   assign Busy = (state == RUN);
   assign Done = (state == DONE);

endmodule

// File: doc/seq_mult_n.md
# seq_mult_n

Parametrised sequential shift-add multiplier, the W-bit successor to the 8-bit lab multiplier. Multiplier is held in register B; a W-bit multiplicand arrives on Din; the 2W-bit product ends in {A,B} with sign/carry bit X. Adds unsigned mode, a Busy/Done handshake, single-cycle add-and-shift iterations and chained multiplication. Sits between the synchronised switch/button inputs and the hex display drivers.

## Interface
- W, default 8: operand width; W >= 2. Counter width is $clog2(W).
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Load_B  in  1  load Din into B and clear A and X; honoured only in IDLE or DONE.
- Start  in  1  level; begins a multiply in IDLE.
- SignedMode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with Start.
- Din  in  W  multiplicand on Start; multiplier on Load_B.
- Aval  out  W  register A, the upper product half.
- Bval  out  W  register B, the lower product half.
- X  out  1  sign-extension bit of A.
- Busy  out  1  high in RUN.
- Done  out  1  high in DONE.

## Operation
- Registers: A, B, X, multiplicand M (W bits), mode bit Sm, count, state.
- IDLE:
  - Load_B=1: B<=Din, A<=0, X<=0. Load_B beats Start in the same cycle; Start is ignored that cycle.
  - Else Start=1: M<=Din, Sm<=SignedMode, A<=0, X<=0, count<=0, go to RUN.
- RUN, one iteration per cycle:
  - ext(v) is a (W+1)-bit extension: sign-extend if Sm, zero-extend otherwise.
  - If B[0]=1: sum = ext(A) + ext(M). When Sm=1 and count=W-1, sum = ext(A) - ext(M) instead.
  - If B[0]=0: sum = ext(A).
  - Shift: A<=sum[W:1], B<={sum[0],B[W-1:1]}, X<=Sm ? sum[W] : 0.
  - count<=count+1. When count=W-1, go to DONE.
  - Load_B, Start and SignedMode are ignored during RUN.
- DONE:
  - Product is {A,B}. In signed mode X equals A[W-1].
  - Go to IDLE when Start=0. A held Start never retriggers.
  - Load_B is honoured in DONE, with the same action as in IDLE; the state stays DONE.
- Chaining: a new Start without Load_B multiplies the lower half B by the new Din. A is cleared first.
- Arithmetic: all sums are W+1 bits with no overflow. The signed product of -2^(W-1) by -2^(W-1) is exact.

## Timing
- Reset: A=0, B=0, X=0, M=0, count=0, state=IDLE, Busy=0, Done=0. Reset takes effect immediately.
- Reset mid-RUN aborts the operation; the partial product is lost.
- Start sampled at edge k gives RUN after edges k+1..k+W. DONE is entered at edge k+W, so Done is high from that edge.
- Busy is high for exactly W cycles. Done stays high until the first edge that samples Start=0.
- Minimum Start-to-Start spacing is W+2 cycles, because Start must be seen low once.
- Outputs come directly from registers, with no combinational path from inputs.

## Test plan
- W=8, signed: Load_B Din=0xFD, then Start Din=0x07 -> after 8 RUN cycles A=0xFF, B=0xEB, X=1, Done=1; Busy high exactly 8 cycles.
- W=8 chained: from the previous result, drop Start, then Start Din=0x02 (signed) -> A=0xFF, B=0xD6 (-42).
- W=8, unsigned: B=0xFF, Start Din=0xFF -> A=0xFE, B=0x01, X=0. Same operands in signed mode -> A=0x00, B=0x01.
- W=8 corners: signed 0x80 x 0x80 -> A=0x40, B=0x00, X=0. Multiplier 0x00 with any Din -> A=0, B=0.
- W=16, signed: B=0x8000, Start Din=0x7FFF -> A=0xC000, B=0x8000, X=1 after 16 cycles.
- Control corners:
  - Start held 40 cycles -> exactly one multiply.
  - Load_B and Start together in IDLE -> only the load occurs.
  - Load_B during RUN -> ignored.
  - Reset asserted at RUN cycle 3 -> all registers 0 and state IDLE immediately; next Start works normally.
